// File: rtl/core_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// core_hazard_ctrl
//   Hazard and stall/flush scheduler for the 5-stage 64-bit core. Detects
//   load-use hazards between IF/ID and ID/EX, flushes on taken branches and
//   MEM exceptions, and freezes the whole pipeline while a data-memory access
//   is outstanding. A three-state FSM (RUN/WAIT/FLUSH) sequences memory waits,
//   a wait timeout (bus error) and the one-cycle post-exception flush window.
//
// Parameters
//   MAX_WAIT        cycles of dmem_req without dmem_ready before bus_err (2..255)
//
// Ports
//   clock           rising-edge clock
//   reset           asynchronous active-low reset
//   id_rs, id_rt    source registers of the IF/ID instruction
//   id_B_is_reg     rt is a real register source
//   ex_mem_read     ID/EX holds a load
//   ex_write_enable ID/EX writes a register
//   ex_W_regnum     destination register of ID/EX
//   branch_taken    EX resolved a taken branch/jump
//   exc_take        MEM raises an exception / ERET redirect
//   dmem_req        MEM access outstanding
//   dmem_ready      memory completes the access this cycle
//   perf_clear      synchronous clear of stall_count
//   if_stall        hold PC and IF/ID
//   id_stall        bubble into ID/EX
//   if_flush        IF/ID becomes a NOP
//   id_flush        ID/EX becomes a NOP
//   ex_flush        EX/MEM becomes a NOP
//   freeze          every pipeline register holds
//   bus_err         one-cycle registered pulse after a memory timeout
//   state           FSM state (RUN=0, WAIT=1, FLUSH=2)
//   stall_count     stall cycle counter
//
// Build option
//   HAZARD_PERF_EN  when defined, stall_count counts freeze|if_stall cycles
//                   (saturating, cleared by perf_clear); otherwise it is 0.
// ---------------------------------------------------------------------------
module core_hazard_ctrl #(
   parameter int MAX_WAIT = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_B_is_reg,
   input  logic        ex_mem_read,
   input  logic        ex_write_enable,
   input  logic [4:0]  ex_W_regnum,
   input  logic        branch_taken,
   input  logic        exc_take,
   input  logic        dmem_req,
   input  logic        dmem_ready,
   input  logic        perf_clear,
   output logic        if_stall,
   output logic        id_stall,
   output logic        if_flush,
   output logic        id_flush,
   output logic        ex_flush,
   output logic        freeze,
   output logic        bus_err,
   output logic [1:0]  state,
   output logic [31:0] stall_count
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_WAIT  = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

   state_t     state_reg, state_next;
   logic [7:0] wait_cnt_reg, wait_cnt_next;
   logic       bus_err_reg, bus_err_next;
   logic       lu;

   // A load in EX whose destination is read by the instruction in ID.
   // r0 is hardwired to zero so it can never carry a dependency.
   assign lu = ex_mem_read && ex_write_enable && (ex_W_regnum != 5'd0) &&
               ((ex_W_regnum == id_rs) || (id_B_is_reg && (ex_W_regnum == id_rt)));

   always_comb begin
      if_stall      = 1'b0;
      id_stall      = 1'b0;
      if_flush      = 1'b0;
      id_flush      = 1'b0;
      ex_flush      = 1'b0;
      freeze        = 1'b0;
      bus_err_next  = 1'b0;
      state_next    = state_reg;
      wait_cnt_next = 8'd0;

      case (state_reg)
         ST_RUN: begin
            if (dmem_req && !dmem_ready) begin
               // This cycle already counts as the first wait cycle.
               freeze        = 1'b1;
               state_next    = ST_WAIT;
               wait_cnt_next = 8'd1;
            end else if (exc_take) begin
               if_flush   = 1'b1;
               id_flush   = 1'b1;
               ex_flush   = 1'b1;
               state_next = ST_FLUSH;
            end else if (branch_taken) begin
               if_flush = 1'b1;
               id_flush = 1'b1;
            end else if (lu) begin
               if_stall = 1'b1;
               id_stall = 1'b1;
            end
         end
         ST_WAIT: begin
            // Hazard/branch/exception inputs are ignored here: the frozen
            // stages will present them again once the pipeline moves.
            if (dmem_ready) begin
               state_next = ST_RUN;
            end else if (wait_cnt_reg == MAX_WAIT_C) begin
               // Timeout: release the freeze and discard the younger stages.
               bus_err_next = 1'b1;
               if_flush     = 1'b1;
               id_flush     = 1'b1;
               ex_flush     = 1'b1;
               state_next   = ST_FLUSH;
            end else begin
               freeze        = 1'b1;
               wait_cnt_next = wait_cnt_reg + 8'd1;
            end
         end
         ST_FLUSH: begin
            // Single cycle; a dmem_req arriving now is served from RUN next.
            if_flush   = 1'b1;
            id_flush   = 1'b1;
            state_next = ST_RUN;
         end
         default: begin
            state_next = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg    <= ST_RUN;
         wait_cnt_reg <= 8'd0;
         bus_err_reg  <= 1'b0;
      end else begin
         state_reg    <= state_next;
         wait_cnt_reg <= wait_cnt_next;
         bus_err_reg  <= bus_err_next;
      end
   end

   assign state   = state_reg;
   assign bus_err = bus_err_reg;

`ifdef HAZARD_PERF_EN
   logic [31:0] stall_count_reg;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stall_count_reg <= 32'd0;
      end else if (perf_clear) begin
         stall_count_reg <= 32'd0;
      end else if ((freeze || if_stall) && (stall_count_reg != 32'hFFFF_FFFF)) begin
         stall_count_reg <= stall_count_reg + 32'd1;
      end
   end

   assign stall_count = stall_count_reg;
`else
   logic unused_perf_clear;
   assign unused_perf_clear = perf_clear;
   assign stall_count       = 32'd0;
`endif

endmodule

// File: doc/core_hazard_ctrl.md
# core_hazard_ctrl

Pipeline hazard and stall/flush scheduler for the 5-stage 64-bit core. It watches the decoded sources in IF/ID, the instruction in ID/EX, the EX branch resolution, MEM-stage exceptions and the data-memory handshake. From these it drives the IF hold, the ID bubble, per-stage flushes and a global freeze. A small FSM sequences multi-cycle memory waits with a timeout and the post-exception flush window.

## Interface
- `MAX_WAIT`, 255: cycles of `dmem_req` without `dmem_ready` before a bus error is raised. Legal range 2..255.
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low; 0 forces the reset state immediately.
- `id_rs`, `id_rt` in 5 each: source register numbers of the instruction in IF/ID.
- `id_B_is_reg` in 1: rt is a real register source.
- `ex_mem_read` in 1: ID/EX holds a load.
- `ex_write_enable` in 1: ID/EX writes a register.
- `ex_W_regnum` in 5: destination register of ID/EX.
- `branch_taken` in 1: EX resolved a taken branch or jump.
- `exc_take` in 1: MEM raises an exception or ERET redirect.
- `dmem_req` in 1: MEM has an access outstanding.
- `dmem_ready` in 1: memory completes the access this cycle.
- `perf_clear` in 1: synchronous clear of `stall_count`.
- `if_stall` out 1: hold PC and IF/ID.
- `id_stall` out 1: load a bubble into ID/EX (drives the ID stage `stall`).
- `if_flush` out 1: IF/ID becomes a NOP.
- `id_flush` out 1: ID/EX becomes a NOP (drives the ID stage `flush`).
- `ex_flush` out 1: EX/MEM becomes a NOP.
- `freeze` out 1: every pipeline register holds.
- `bus_err` out 1: one-cycle pulse on memory timeout.
- `state` out 2: FSM state. RUN=0, WAIT=1, FLUSH=2.
- `stall_count` out 32: stall cycle counter (see Configuration).

## Operation
- Load-use hazard, `lu`, is asserted when all of the following hold:
  - `ex_mem_read` & `ex_write_enable` & (`ex_W_regnum` != 0);
  - and either `ex_W_regnum` == `id_rs`, or `id_B_is_reg` & (`ex_W_regnum` == `id_rt`).
- RUN state:
  - If `dmem_req` & !`dmem_ready`: `freeze`=1 and all other outputs 0. Next state WAIT, `wait_cnt`=1.
  - Else if `exc_take`: `if_flush`=`id_flush`=`ex_flush`=1. Next state FLUSH.
  - Else if `branch_taken`: `if_flush`=`id_flush`=1. Stay in RUN. `lu` is ignored in this cycle.
  - Else if `lu`: `if_stall`=`id_stall`=1 for this cycle only.
- WAIT state:
  - Outputs: `freeze`=!`dmem_ready`. `exc_take`, `branch_taken` and `lu` are ignored; the held stages re-present them.
  - If `dmem_ready`: next state RUN.
  - Else if `wait_cnt` == `MAX_WAIT`: `bus_err`=1, `freeze`=0, `if_flush`=`id_flush`=`ex_flush`=1. Next state FLUSH.
  - Otherwise `wait_cnt` increments. It is 8-bit and never wraps, because the compare fires first.
- FLUSH state:
  - Held for exactly one cycle: `if_flush`=`id_flush`=1, hazard detection suppressed. Next state RUN.
  - A new `dmem_req` seen in FLUSH is handled in the following RUN cycle.
- Priority across all states: reset > freeze condition > exception/timeout > branch > load-use.
- `if_stall`, `id_stall`, the flushes and `freeze` are combinational from current state and inputs. `state`, `wait_cnt`, `bus_err` and `stall_count` are registered. `bus_err` is a registered pulse that appears in the cycle after the timeout compare.

## Timing
- Reset values (reset=0):
  - `state`=RUN, `wait_cnt`=0, `bus_err`=0, `stall_count`=0.
  - Combinational outputs evaluate with RUN semantics.
- Load-use costs exactly one bubble. In the next cycle the load has left EX, so `lu` deasserts naturally.
- Memory wait: freeze lasts from the first request cycle until the cycle in which `dmem_ready`=1. That cycle is unfrozen, and the pipeline advances on its clock edge.
- A timeout ends the freeze in the cycle of `bus_err`.
- Reset asserted mid-WAIT aborts the wait: no `bus_err`, and `state` is RUN immediately (asynchronous).
- `exc_take` together with `branch_taken`: the exception wins and `ex_flush`=1.

## Configuration
- `HAZARD_PERF_EN` defined:
  - `stall_count` increments on every clock edge where `freeze` | `if_stall` is 1.
  - It saturates at 32'hFFFF_FFFF.
  - `perf_clear` zeroes it and takes precedence over the increment.
- `HAZARD_PERF_EN` undefined: `stall_count` is tied to 0 and `perf_clear` is unused. No counter flops are built.

## Test plan
- `ex_mem_read`=1, `ex_write_enable`=1, `ex_W_regnum`=5, `id_rs`=5 -> `if_stall`=`id_stall`=1 for one cycle. Repeat with `ex_W_regnum`=0 -> no stall.
- `id_rt`=7, `ex_W_regnum`=7, load in EX, `id_B_is_reg`=0 -> no stall. With `id_B_is_reg`=1 -> one-cycle stall.
- `dmem_req`=1, `dmem_ready` low for 3 cycles then high -> `freeze`=1 for 3 cycles, `state` sequence 0,1,1,1,0. No `bus_err`.
- `MAX_WAIT`=4, `dmem_ready` held low -> `bus_err` pulses once. `ex_flush`=1 in the timeout cycle. `state` goes to FLUSH for one cycle, then RUN.
- `exc_take` and `branch_taken` together with `lu`=1 -> all three flushes asserted, `id_stall`=0. The next cycle is FLUSH with `lu` suppressed.
- `HAZARD_PERF_EN`: 1 load-use stall plus 3 freeze cycles -> `stall_count`=4. `perf_clear` -> 0. Reset asserted mid-WAIT -> `state`=0 immediately, `stall_count`=0.
